// File: rtl/bundle_acc.sv
// ---------------------------------------------------------------------------
// bundle_acc
//
// Bundles (majority-votes) a stream of hypervectors. Each accepted vector
// moves one signed saturating counter per bit up (bit = 1) or down (bit = 0).
// The vector flagged "last" closes the bundle: every updated counter is
// binarized (> 0 -> 1, tie or negative -> 0). The result is presented with a
// valid/ready handshake together with the number of vectors it was built from.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   exec       : input-side enable; 0 stalls accumulation
//   clear      : synchronous abort of the bundle in progress
//   in_valid   : data/last are valid
//   in_ready   : block can accept a vector this cycle
//   data       : permuted hypervector, DIM+1 bits
//   last       : data is the final vector of the bundle
//   out_valid  : result/vec_count are valid
//   out_ready  : downstream accepts the result
//   result     : binarized bundle, DIM+1 bits
//   vec_count  : number of vectors in the presented result (saturating)
// ---------------------------------------------------------------------------
module bundle_acc #(
   parameter int DIM   = 1023,
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           exec,
   input  logic           clear,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DIM:0]   data,
   input  logic           last,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DIM:0]   result,
   output logic [15:0]    vec_count
);

   // Symmetric saturation limits: +(2^(CNT_W-1)-1) and its negation. The
   // most negative two's-complement code is never used, so the counter range
   // is balanced around zero.
   localparam int                      CNT_MAX_I = (1 << (CNT_W - 1)) - 1;
   localparam logic signed [CNT_W-1:0] CNT_MAX   = CNT_W'(CNT_MAX_I);
   localparam logic signed [CNT_W-1:0] CNT_MIN   = CNT_W'(-CNT_MAX_I);
   localparam logic signed [CNT_W-1:0] CNT_ZERO  = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic signed [CNT_W-1:0] cnt_q   [DIM+1];
   logic signed [CNT_W-1:0] cnt_d   [DIM+1];
   logic signed [CNT_W-1:0] cnt_upd [DIM+1];
   logic [15:0]             count_q, count_d;
   logic [DIM:0]            result_q, result_d;
   logic [15:0]             vcnt_q, vcnt_d;

   logic accept;
   logic [15:0] count_inc;

   // in_ready is forced low during reset even though the state is IDLE then.
   assign in_ready  = rst_n & exec & (state_q != OUT);
   assign accept    = in_valid & in_ready & ~clear;
   assign out_valid = (state_q == OUT);
   assign result    = result_q;
   assign vec_count = vcnt_q;

   // Saturating "count + 1": used both for the running internal count and for
   // the published vec_count (which includes the last vector).
   assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   // Per-bit saturating vote. The counters never leave [CNT_MIN, CNT_MAX], so
   // comparing against the limit is enough to prevent wrap-around.
   always_comb begin
      for (int i = 0; i <= DIM; i++) begin
         if (data[i]) begin
            cnt_upd[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(1);
         end else begin
            cnt_upd[i] = (cnt_q[i] == CNT_MIN) ? CNT_MIN : cnt_q[i] - CNT_W'(1);
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      count_d  = count_q;
      result_d = result_q;
      vcnt_d   = vcnt_q;

      if (clear) begin
         // Abort wins over accept and handshake; the presented result and
         // vec_count are deliberately left untouched.
         state_d = IDLE;
         count_d = '0;
         for (int i = 0; i <= DIM; i++) cnt_d[i] = CNT_ZERO;
      end else if (accept) begin
         if (last) begin
            state_d = OUT;
            vcnt_d  = count_inc;
            count_d = '0;
            for (int i = 0; i <= DIM; i++) begin
               // Ties (counter == 0) resolve to 0.
               result_d[i] = (cnt_upd[i] > CNT_ZERO);
               cnt_d[i]    = CNT_ZERO;
            end
         end else begin
            state_d = ACC;
            count_d = count_inc;
            cnt_d   = cnt_upd;
         end
      end else if (state_q == OUT && out_ready) begin
         // Output handshake does not depend on exec.
         state_d = IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples values from before the edge regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         result_q <= '0;
         vcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         result_q <= result_d;
         vcnt_q   <= vcnt_d;
      end
   end

   // NOTE: the counter array is reset on purpose: a reset in mid-bundle must
   // discard partial votes, so this storage cannot be left uninitialised.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= DIM; i++) cnt_q[i] <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bundle_acc.sv
// ---------------------------------------------------------------------------
// tb_bundle_acc
//
// Directed bench for bundle_acc with DIM=7, CNT_W=4. Expected results are
// pushed into a queue when a bundle is issued; a monitor pops and compares on
// every output handshake.
// ---------------------------------------------------------------------------
module tb_bundle_acc;

   logic        clk;
   logic        rst_n;
   logic        exec;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  data;
   logic        last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  result;
   logic [15:0] vec_count;

   typedef struct packed {
      logic [7:0]  res;
      logic [15:0] vc;
   } exp_t;

   exp_t exp_q[$];
   int   total  = 0;
   int   passed = 0;

   bundle_acc #(.DIM(7), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .exec      (exec),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data      (data),
      .last      (last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .vec_count (vec_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic push(input logic [7:0] r, input logic [15:0] vc);
      exp_t e;
      e.res = r;
      e.vc  = vc;
      exp_q.push_back(e);
   endtask

   // Present one vector and hold it until it has been accepted.
   task automatic send(input logic [7:0] d, input logic l);
      @(negedge clk);
      data     = d;
      last     = l;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
      check("in_ready_for_send", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      last     = 1'b0;
      if (l) check("out_valid_latency", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic set_out_ready(input logic v);
      @(posedge clk);
      #1 out_ready = v;
   endtask

   task automatic check_reset_outputs();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result",    {24'd0, result},    32'd0);
      check("rst_vec_count", {16'd0, vec_count}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd0);
   endtask

   // Scoreboard monitor: compares every transferred result.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result",    {24'd0, result},    {24'd0, e.res});
            check("vec_count", {16'd0, vec_count}, {16'd0, e.vc});
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      exec      = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      data      = '0;
      last      = 1'b0;
      out_ready = 1'b1;

      // Reset state.
      #12;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

      // Majority vote.
      push(8'hE8, 16'd3);
      send(8'hF0, 1'b0);
      send(8'hCC, 1'b0);
      send(8'hAA, 1'b1);

      // Tie resolves to 0.
      push(8'h0F, 16'd2);
      send(8'hFF, 1'b0);
      send(8'h0F, 1'b1);

      // Single-vector bundle.
      push(8'hA5, 16'd1);
      send(8'hA5, 1'b1);

      // Saturation: bit 0 clamps at +7, so 9 down-votes end at -2.
      push(8'h00, 16'd19);
      for (int k = 0; k < 10; k++) send(8'h01, 1'b0);
      for (int k = 0; k < 9; k++)  send(8'h00, (k == 8));

      // Backpressure with in_valid held high.
      set_out_ready(1'b0);
      push(8'h5A, 16'd1);
      send(8'h5A, 1'b1);
      data     = 8'hFF;
      last     = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_result",    {24'd0, result},    32'h5A);
         check("bp_vec_count", {16'd0, vec_count}, 32'd1);
         check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      end
      set_out_ready(1'b1);
      @(negedge clk);
      @(negedge clk);
      check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
      check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
      in_valid = 1'b0;
      last     = 1'b0;

      // Stall then clear together with an accept attempt.
      send(8'hFF, 1'b0);
      send(8'hFF, 1'b0);
      @(negedge clk);
      exec     = 1'b0;
      data     = 8'h00;
      last     = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_in_ready",  {31'd0, in_ready},  32'd0);
         check("stall_out_valid", {31'd0, out_valid}, 32'd0);
      end
      exec  = 1'b1;
      clear = 1'b1;
      data  = 8'hFF;
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      last     = 1'b0;
      check("clear_out_valid", {31'd0, out_valid}, 32'd0);
      check("clear_keeps_result", {24'd0, result}, 32'h5A);
      push(8'h3C, 16'd1);
      send(8'h3C, 1'b1);

      // Reset while the result is held in OUT.
      set_out_ready(1'b0);
      send(8'hFF, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // Reset in the middle of accumulation: no residual votes or count.
      send(8'hFF, 1'b0);
      send(8'hFF, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      push(8'h00, 16'd1);
      send(8'h00, 1'b1);

      for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
